// File: rtl/noc_pkg.sv
// Shared constants and the queued-flit type for the NoC router and its input FIFOs.
package noc_pkg;

  localparam int NPORTS_DEF = 4;
  localparam int DW_DEF     = 8;
  localparam int DEPTH_DEF  = 4;

  // Port address width; a single port still needs one address bit.
  function automatic int noc_aw(input int nports);
    return (nports < 2) ? 1 : $clog2(nports);
  endfunction

  localparam int AW_DEF = noc_aw(NPORTS_DEF);

  typedef struct packed {
    logic [DW_DEF-1:0] data;
    logic [AW_DEF-1:0] dest;
  } noc_entry_t;

endpackage

// File: rtl/noc_router_if.sv
// Control, flit and handshake bundle between a NoC router and its environment.
interface noc_router_if #(
  parameter int NPORTS = noc_pkg::NPORTS_DEF,
  parameter int DW     = noc_pkg::DW_DEF
);
  localparam int AW = noc_pkg::noc_aw(NPORTS);

  logic                 CS;
  logic                 CNFG;
  logic                 LOAD;
  logic [AW-1:0]        In_add;
  logic [AW-1:0]        out_add;
  logic [NPORTS*DW-1:0] port_in;
  logic [NPORTS-1:0]    en;
  logic [NPORTS-1:0]    in_ready;
  logic [NPORTS*DW-1:0] port_out;
  logic [NPORTS-1:0]    out_valid;
  logic [NPORTS-1:0]    out_ready;

  modport master (
    output CS, CNFG, LOAD, In_add, out_add, port_in, en, out_ready,
    input  in_ready, port_out, out_valid
  );

  modport slave (
    input  CS, CNFG, LOAD, In_add, out_add, port_in, en, out_ready,
    output in_ready, port_out, out_valid
  );
endinterface

// File: rtl/noc_fifo.sv
// Synchronous input FIFO holding flits tagged with their destination port.
module noc_fifo
  import noc_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = noc_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // A push and pop on the same edge leave the occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_router.sv
// NPORTS x NPORTS flit router: per-input FIFOs, a programmable route table and
// per-output round-robin arbitration into a single registered output stage.
module noc_router
  import noc_pkg::*;
#(
  parameter int NPORTS = NPORTS_DEF,
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic          CLK,
  input logic          RES,
  noc_router_if.slave  bus
);

  localparam int AW = noc_aw(NPORTS);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] dest;
  } entry_t;

  logic [AW-1:0]     route_tbl  [NPORTS];
  logic [AW-1:0]     rr_ptr     [NPORTS];
  logic [DW-1:0]     out_data   [NPORTS];
  logic [NPORTS-1:0] out_vld;

  entry_t            fifo_wdata [NPORTS];
  entry_t            fifo_head  [NPORTS];
  logic [NPORTS-1:0] fifo_full;
  logic [NPORTS-1:0] fifo_empty;
  logic [NPORTS-1:0] push;
  logic [NPORTS-1:0] pop;

  logic [NPORTS-1:0] out_free;
  logic [NPORTS-1:0] grant_vld;
  logic [AW-1:0]     grant_idx  [NPORTS];

  assign bus.in_ready  = {NPORTS{~RES & bus.CS & ~bus.CNFG}} & ~fifo_full;
  assign push          = bus.en & bus.in_ready;
  assign bus.out_valid = out_vld;

  // Flits are tagged with the route in force on their acceptance edge.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      fifo_wdata[i].data = bus.port_in[i*DW +: DW];
      fifo_wdata[i].dest = route_tbl[i];
    end
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    noc_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk   (CLK),
      .rst   (RES),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (fifo_wdata[i]),
      .rdata (fifo_head[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i])
    );

    assign bus.port_out[i*DW +: DW] = out_data[i];
  end

  // Each head targets one output, so an input is granted by at most one arbiter.
  always_comb begin
    logic [AW-1:0] idx;
    idx       = '0;
    grant_vld = '0;
    pop       = '0;
    for (int o = 0; o < NPORTS; o++) begin
      grant_idx[o] = '0;
      out_free[o]  = ~out_vld[o] | bus.out_ready[o];
    end
    for (int o = 0; o < NPORTS; o++) begin
      if (bus.CS && out_free[o]) begin
        for (int k = 0; k < NPORTS; k++) begin
          idx = AW'((int'(rr_ptr[o]) + k) % NPORTS);
          if (!grant_vld[o] && !fifo_empty[idx] && fifo_head[idx].dest == AW'(o)) begin
            grant_vld[o] = 1'b1;
            grant_idx[o] = idx;
          end
        end
      end
    end
    for (int o = 0; o < NPORTS; o++) begin
      if (grant_vld[o]) pop[grant_idx[o]] = 1'b1;
    end
  end

  // With CS low everything holds, including an output that downstream is ready to take.
  always_ff @(posedge CLK) begin
    if (RES) begin
      for (int i = 0; i < NPORTS; i++) begin
        route_tbl[i] <= AW'(i);
        rr_ptr[i]    <= '0;
        out_data[i]  <= '0;
      end
      out_vld <= '0;
    end else if (bus.CS) begin
      if (bus.CNFG && bus.LOAD && int'(bus.out_add) < NPORTS && int'(bus.In_add) < NPORTS) begin
        route_tbl[bus.In_add] <= bus.out_add;
      end
      for (int o = 0; o < NPORTS; o++) begin
        if (grant_vld[o]) begin
          out_data[o] <= fifo_head[grant_idx[o]].data;
          out_vld[o]  <= 1'b1;
          rr_ptr[o]   <= AW'((int'(grant_idx[o]) + 1) % NPORTS);
        end else if (out_vld[o] && bus.out_ready[o]) begin
          out_vld[o]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_router.sv
// Scoreboard bench for noc_router (4 ports, 8-bit flits, depth-4 FIFOs).
module tb_noc_router;
  import noc_pkg::*;

  localparam int NP = 4;
  localparam int W  = 8;

  logic CLK = 1'b0;
  logic RES;
  always #5 CLK = ~CLK;

  noc_router_if #(.NPORTS(NP), .DW(W)) bus ();

  noc_router #(.NPORTS(NP), .DW(W), .DEPTH(4)) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [NP][$];
  logic [1:0] tb_rt [NP];
  logic [7:0] exp_v;
  logic [3:0] seen;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Every flit handed downstream must be the oldest one still owed to that output.
  always @(negedge CLK) begin
    if (RES === 1'b0 && bus.CS === 1'b1) begin
      for (int o = 0; o < NP; o++) begin
        if (bus.out_valid[o] && bus.out_ready[o]) begin
          if (exp_q[o].size() == 0) begin
            checkOutput($sformatf("sb_spurious_o%0d", o), 32'(bus.out_valid[o]), 32'd0);
          end else begin
            exp_v = exp_q[o].pop_front();
            checkOutput($sformatf("sb_data_o%0d", o), 32'(bus.port_out[o*W +: W]), 32'(exp_v));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic flushModel();
    for (int i = 0; i < NP; i++) begin
      exp_q[i].delete();
      tb_rt[i] = 2'(i);
    end
  endtask

  task automatic resetDut();
    RES     = 1'b1;
    bus.CS  = 1'b0;
    bus.en  = '0;
    bus.CNFG = 1'b0;
    bus.LOAD = 1'b0;
    flushModel();
    tick();
    RES    = 1'b0;
    bus.CS = 1'b1;
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] data, input logic [3:0] exp_ready);
    bus.en      = mask;
    bus.port_in = data;
    @(negedge CLK);
    checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    for (int i = 0; i < NP; i++) begin
      if (mask[i]) exp_q[tb_rt[i]].push_back(data[i*W +: W]);
    end
    tick();
    bus.en = '0;
  endtask

  task automatic configure(input logic [1:0] src, input logic [1:0] dst);
    bus.CNFG    = 1'b1;
    bus.LOAD    = 1'b1;
    bus.In_add  = src;
    bus.out_add = dst;
    @(negedge CLK);
    checkOutput("cfg_in_ready", 32'(bus.in_ready), 32'd0);
    tb_rt[src] = dst;
    tick();
    bus.CNFG = 1'b0;
    bus.LOAD = 1'b0;
  endtask

  function automatic bit pending();
    for (int i = 0; i < NP; i++) if (exp_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic waitDrain(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      tick();
      n++;
    end
    for (int i = 0; i < NP; i++) checkOutput($sformatf("drain_o%0d", i), 32'(exp_q[i].size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RES           = 1'b1;
    bus.CS        = 1'b0;
    bus.CNFG      = 1'b0;
    bus.LOAD      = 1'b0;
    bus.In_add    = '0;
    bus.out_add   = '0;
    bus.port_in   = '0;
    bus.en        = '0;
    bus.out_ready = '0;
    flushModel();

    // Two reset edges; CS raised during the second must not open the inputs.
    tick();
    bus.CS = 1'b1;
    @(negedge CLK);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    RES = 1'b0;
    @(negedge CLK);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_port_out", bus.port_out, 32'd0);
    checkOutput("idle_in_ready", 32'(bus.in_ready), 32'hF);
    tick();

    $display("[TB] identity route and latency");
    bus.out_ready = 4'hF;
    applyStimulus(4'b0001, 32'h0000_0014, 4'hF);
    @(negedge CLK);
    checkOutput("lat_k_valid", 32'(bus.out_valid), 32'd0);
    @(negedge CLK);
    checkOutput("lat_k1_valid", 32'(bus.out_valid), 32'b0001);
    checkOutput("lat_k1_data", 32'(bus.port_out[7:0]), 32'h14);
    tick();
    waitDrain(10);

    $display("[TB] route table write");
    configure(2'd1, 2'd2);
    applyStimulus(4'b0010, 32'h0000_1E00, 4'hF);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("cfg_out_valid", 32'(bus.out_valid), 32'b0100);
    checkOutput("cfg_out_data", 32'(bus.port_out[23:16]), 32'h1E);
    tick();
    waitDrain(10);

    $display("[TB] contention on output 2");
    resetDut();
    for (int i = 0; i < NP; i++) configure(2'(i), 2'd2);
    bus.out_ready = 4'hF;
    applyStimulus(4'hF, {8'd56, 8'd45, 8'd35, 8'd25}, 4'hF);
    @(negedge CLK);
    checkOutput("cont_first_idle", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("cont_valid_%0d", k), 32'(bus.out_valid), 32'b0100);
    end
    tick();
    waitDrain(10);
    applyStimulus(4'b1010, {8'd99, 8'd0, 8'd77, 8'd0}, 4'hF);
    waitDrain(10);

    $display("[TB] backpressure on output 0");
    resetDut();
    bus.out_ready = 4'hE;
    for (int v = 1; v <= 5; v++) applyStimulus(4'b0001, 32'(v), 4'hF);
    bus.en      = 4'b0001;
    bus.port_in = 32'd6;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'hE);
      checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'b0001);
      checkOutput("bp_hold_data", 32'(bus.port_out[7:0]), 32'd1);
      tick();
    end
    exp_q[0].push_back(8'd6);
    bus.out_ready = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("bp_nogap_%0d", k), 32'(bus.out_valid[0]), 32'd1);
      if (k == 0) checkOutput("bp_still_full", 32'(bus.in_ready[0]), 32'd0);
      if (k == 1) begin
        checkOutput("bp_reopen", 32'(bus.in_ready[0]), 32'd1);
        @(posedge CLK);
        #1;
        bus.en = '0;
      end
    end
    tick();
    waitDrain(10);

    $display("[TB] reset mid-operation");
    bus.out_ready = 4'h0;
    for (int v = 0; v < 4; v++) applyStimulus(4'b0010, 32'(8'hA1 + v) << 8, 4'hF);
    RES         = 1'b1;
    bus.en      = 4'hF;
    bus.port_in = 32'hDEAD_BEEF;
    flushModel();
    tick();
    RES    = 1'b0;
    bus.en = '0;
    @(negedge CLK);
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_data", bus.port_out, 32'd0);
    tick();
    bus.out_ready = 4'hF;
    seen = '0;
    repeat (8) begin
      @(negedge CLK);
      seen |= bus.out_valid;
    end
    checkOutput("mid_rst_nothing", 32'(seen), 32'd0);
    tick();

    $display("[TB] chip select freeze");
    bus.out_ready = 4'h0;
    applyStimulus(4'b1000, 32'h7700_0000, 4'hF);
    applyStimulus(4'b1000, 32'h7800_0000, 4'hF);
    bus.CS        = 1'b0;
    bus.en        = 4'hF;
    bus.port_in   = 32'h1122_3344;
    bus.out_ready = 4'hF;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      checkOutput($sformatf("cs_in_ready_%0d", k), 32'(bus.in_ready), 32'd0);
      checkOutput($sformatf("cs_valid_%0d", k), 32'(bus.out_valid), 32'b1000);
      checkOutput($sformatf("cs_data_%0d", k), bus.port_out, 32'h7700_0000);
    end
    tick();
    bus.en = '0;
    bus.CS = 1'b1;
    waitDrain(20);
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
